reg_block: RTL and testbench

REG_BLOCK -- requirements
Module: reg_block

---
 rtl/reg_block.sv | 105 ++++++++++
 tb/tb_reg_block.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_block.sv
// Register block with per-register software/hardware ownership and a one-cycle request/ack access port.
// Writable registers are stored locally; read-only registers reflect rd_regs.
module reg_block #(
  parameter int                  REG_ADDR_WIDTH = 16,
  parameter int                  NUM_REGS       = 4,
  parameter logic [NUM_REGS-1:0] REG_WRITE_MASK = 4'b1011
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic                     reg_wren,
  input  logic [3:0]               reg_be,
  input  logic                     reg_req,
  output logic [31:0]              reg_rdata,
  output logic                     reg_ack,
  output logic                     reg_err,
  input  logic [NUM_REGS*32-1:0]   rd_regs,
  output logic [NUM_REGS*32-1:0]   wr_regs
);

  logic [REG_ADDR_WIDTH-1:0] reg_idx;
  logic                      addr_aligned;
  logic                      idx_in_range;
  logic                      idx_writable;
  logic [NUM_REGS-1:0]       idx_sel;
  logic [31:0]               rd_value;
  logic                      access_err;
  logic                      accept;
  logic [31:0]               be_mask;

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  // Address decode: word index, alignment, range and ownership of the target register.
  always_comb begin
    reg_idx      = {2'b00, reg_addr[REG_ADDR_WIDTH-1:2]};
    addr_aligned = (reg_addr[1:0] == 2'b00);
    idx_in_range = 1'b0;
    idx_writable = 1'b0;
    idx_sel      = '0;
    rd_value     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_idx == REG_ADDR_WIDTH'(i)) begin
        idx_sel[i]   = 1'b1;
        idx_in_range = 1'b1;
        idx_writable = REG_WRITE_MASK[i];
        rd_value     = REG_WRITE_MASK[i] ? regs_q[i] : rd_regs[i*32 +: 32];
      end
    end
    access_err = !addr_aligned || !idx_in_range || (reg_wren && !idx_writable);
    accept     = reg_req && !rst;
    be_mask    = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
  end

  // Next-state for the register file and the registered response.
  always_comb begin
    ack_d   = accept;
    err_d   = accept && access_err;
    rdata_d = (accept && !reg_wren && !access_err) ? rd_value : 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (!REG_WRITE_MASK[i]) begin
        regs_d[i] = 32'h0;
      end else if (accept && reg_wren && !access_err && idx_sel[i]) begin
        regs_d[i] = (regs_q[i] & ~be_mask) | (reg_wdata & be_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Outputs are forced quiet for the whole time rst is high, not just from the next edge.
  always_comb begin
    reg_ack   = ack_q && !rst;
    reg_err   = err_q && !rst;
    reg_rdata = rst ? 32'h0 : rdata_q;
    wr_regs   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (REG_WRITE_MASK[i] && !rst) begin
        wr_regs[i*32 +: 32] = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_block.sv
// Self-checking bench for reg_block: a reference model pushes expected responses
// into a queue as requests are driven; they are popped when the ack cycle is sampled.
module tb_reg_block;

  localparam int         AW   = 16;
  localparam int         NR   = 4;
  localparam logic [3:0] MASK = 4'b1011;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  reg_addr;
  logic [31:0]    reg_wdata;
  logic           reg_wren;
  logic [3:0]     reg_be;
  logic           reg_req;
  logic [31:0]    reg_rdata;
  logic           reg_ack;
  logic           reg_err;
  logic [NR*32-1:0] rd_regs;
  logic [NR*32-1:0] wr_regs;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [NR];
  int          tests_run    = 0;
  int          tests_failed = 0;

  reg_block #(
    .REG_ADDR_WIDTH(AW),
    .NUM_REGS      (NR),
    .REG_WRITE_MASK(MASK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wren (reg_wren),
    .reg_be   (reg_be),
    .reg_req  (reg_req),
    .reg_rdata(reg_rdata),
    .reg_ack  (reg_ack),
    .reg_err  (reg_err),
    .rd_regs  (rd_regs),
    .wr_regs  (wr_regs)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, updates the model, then checks the outputs just after the edge.
  task automatic applyStimulus(input logic r, input logic req, input logic wren,
                               input logic [AW-1:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    exp_t e;
    int   idx;
    logic err;
    rst       = r;
    reg_req   = req;
    reg_wren  = wren;
    reg_addr  = addr;
    reg_wdata = wdata;
    reg_be    = be;
    if (req && !r) begin
      idx = int'(addr >> 2);
      if (idx >= NR || addr[1:0] != 2'b00) err = 1'b1;
      else                                 err = wren && !MASK[idx];
      e.err   = err;
      e.rdata = 32'h0;
      if (!err && !wren) e.rdata = MASK[idx] ? model[idx] : rd_regs[idx*32 +: 32];
      if (!err && wren) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < NR; i++) model[i] = 32'h0;
      #1;
      checkOutput("rst_ack", {127'h0, reg_ack}, 128'h0);
      checkOutput("rst_wr_regs", wr_regs, 128'h0);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("ack", {127'h0, reg_ack}, 128'h1);
      checkOutput("err", {127'h0, reg_err}, {127'h0, e.err});
      checkOutput("rdata", {96'h0, reg_rdata}, {96'h0, e.rdata});
    end else begin
      checkOutput("idle_ack", {127'h0, reg_ack}, 128'h0);
      checkOutput("idle_err", {127'h0, reg_err}, 128'h0);
      checkOutput("idle_rdata", {96'h0, reg_rdata}, 128'h0);
    end
    for (int i = 0; i < NR; i++) begin
      checkOutput($sformatf("wr_regs[%0d]", i), {96'h0, wr_regs[i*32 +: 32]},
                  {96'h0, (MASK[i] ? model[i] : 32'h0)});
    end
  endtask

  initial begin
    rd_regs = {32'h3333_3333, 32'h0000_FFFF, 32'h1111_1111, 32'h0BAD_0000};
    for (int i = 0; i < NR; i++) model[i] = 32'h0;

    applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(1, 1, 1, 16'h0, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);

    // Post-reset reads, including the hardware-sourced register.
    applyStimulus(0, 1, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'h4, 32'h0, 4'hF);
    applyStimulus(0, 1, 0, 16'hC, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'h8, 32'h0, 4'h0);
    applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);

    applyStimulus(0, 1, 1, 16'h0, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 1, 1, 16'h4, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 1, 1, 16'hC, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(0, 1, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'h4, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'hC, 32'h0, 4'h0);

    // Error cases: read-only write, out of range, unaligned.
    applyStimulus(0, 1, 1, 16'h8, 32'h1234_5678, 4'hF);
    applyStimulus(0, 1, 1, 16'h10, 32'h1234_5678, 4'hF);
    applyStimulus(0, 1, 0, 16'h10, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'h2, 32'h0, 4'h0);
    applyStimulus(0, 1, 1, 16'h1, 32'h1234_5678, 4'hF);

    applyStimulus(0, 1, 1, 16'h4, 32'h0, 4'hF);
    applyStimulus(0, 1, 1, 16'h4, 32'hAABB_CCDD, 4'h5);
    applyStimulus(0, 1, 0, 16'h4, 32'h0, 4'h0);
    applyStimulus(0, 1, 1, 16'h4, 32'hFFFF_FFFF, 4'h0);
    applyStimulus(0, 1, 0, 16'h4, 32'h0, 4'h0);

    applyStimulus(0, 1, 1, 16'h0, 32'h1111_1111, 4'hF);
    applyStimulus(0, 1, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 1, 16'hC, 32'h5555_AAAA, 4'hF);
    applyStimulus(1, 1, 1, 16'h0, 32'h2222_2222, 4'hF);
    applyStimulus(1, 0, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'h0, 32'h0, 4'h0);
    applyStimulus(0, 1, 0, 16'hC, 32'h0, 4'h0);

    // Randomised mix of reads/writes with changing hardware values.
    for (int n = 0; n < 60; n++) begin
      rd_regs[2*32 +: 32] = $urandom;
      applyStimulus(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 19)), $urandom, 4'($urandom_range(0, 15)));
    end
    applyStimulus(0, 0, 0, 16'h0, 32'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
